// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests and fills the IF/ID
// register, parking one fetched word in a hold buffer while decode is stalled.
module pc_fetch_stage #(
    parameter int unsigned     SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] pc_plus4_in,
    output logic [SIZE-1:0] pc_out,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [SIZE-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [SIZE-1:0] redirect_pc,
    output logic            if_valid,
    output logic [SIZE-1:0] if_instr,
    output logic [SIZE-1:0] if_pc,
    output logic [SIZE-1:0] if_pc_plus4,
    output logic            fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SIZE-1:0] pc;
    logic [SIZE-1:0] hold_instr;
    logic [SIZE-1:0] hold_pc;
    logic [SIZE-1:0] hold_pc_plus4;
    logic            handshake;

    assign pc_out    = pc;
    assign handshake = imem_req & imem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (handshake && stall) state_next = HOLD;
            HOLD:    if (!stall) state_next = FETCH;
            default: state_next = IDLE;
        endcase
        // Redirect outranks stall and any same-cycle handshake.
        if (redirect) state_next = FETCH;
    end

    always_comb begin
        imem_req = (state == FETCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            if_pc         <= '0;
            if_pc_plus4   <= '0;
            hold_instr    <= '0;
            hold_pc       <= '0;
            hold_pc_plus4 <= '0;
            fetch_err     <= 1'b0;
        end else begin
            fetch_err <= redirect & (|redirect_pc[1:0]);
            if (redirect) begin
                pc       <= {redirect_pc[SIZE-1:2], 2'b00};
                if_valid <= 1'b0;
            end else begin
                unique case (state)
                    FETCH: begin
                        if (handshake) begin
                            pc <= pc_plus4_in;
                            if (stall) begin
                                hold_instr    <= imem_rdata;
                                hold_pc       <= pc;
                                hold_pc_plus4 <= pc_plus4_in;
                            end else begin
                                if_valid    <= 1'b1;
                                if_instr    <= imem_rdata;
                                if_pc       <= pc;
                                if_pc_plus4 <= pc_plus4_in;
                            end
                        end else if (!stall) begin
                            if_valid <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            if_valid    <= 1'b1;
                            if_instr    <= hold_instr;
                            if_pc       <= hold_pc;
                            if_pc_plus4 <= hold_pc_plus4;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
